// File: rtl/usb_uart_fifo_bridge.sv
// CPU-side memory-mapped bridge to the usb_uart byte interface: TX and RX byte
// FIFOs plus a status register, with a one-cycle registered ready per access.
module usb_uart_fifo_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        uart_we,
  output logic [7:0]  uart_di,
  input  logic        uart_wait,
  output logic        uart_re,
  input  logic [7:0]  uart_do,
  input  logic        uart_ready
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

  logic           r_ready;
  logic [31:0]    r_rdata;
  logic           r_uart_we;
  logic [7:0]     r_uart_di;
  logic           r_uart_re;
  logic           r_orphan;
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TAW-1:0] r_tx_wr, r_tx_rd;
  logic [TAW:0]   r_tx_cnt;
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [RAW-1:0] r_rx_wr, r_rx_rd;
  logic [RAW:0]   r_rx_cnt;
  logic           r_rx_ovf;

  logic           w_acc, w_wr, w_stat, w_wdat;
  logic           w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic           w_tx_push, w_tx_pop, w_stall, w_flush, w_ovf_clr;
  logic           w_rx_push, w_rx_pop, w_accept, w_tx_remain;
  logic [TAW-1:0] w_tx_rd_nxt;
  logic [7:0]     w_tx_next;
  logic [31:0]    w_status, w_rdata_nxt;
  logic           w_unused;

  assign w_acc      = sel & ~r_ready;
  assign w_wr       = |wstrb;
  assign w_stat     = addr[2];
  assign w_wdat     = w_acc & w_wr & ~w_stat & wstrb[0];
  assign w_tx_full  = (r_tx_cnt == TX_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_push  = w_wdat & ~w_tx_full;
  assign w_stall    = w_wdat & w_tx_full;
  assign w_flush    = w_acc & w_wr & w_stat & wdata[1];
  assign w_ovf_clr  = w_acc & w_wr & w_stat & wdata[3];
  assign w_rx_push  = uart_ready & ~w_rx_full;
  assign w_rx_pop   = w_acc & ~w_wr & ~w_stat & ~w_rx_empty;
  assign w_accept   = r_uart_we & ~uart_wait;
  // A presented byte orphaned by a flush is no longer in the FIFO, so its accept pops nothing.
  assign w_tx_pop    = w_accept & ~r_orphan;
  assign w_tx_rd_nxt = r_tx_rd + TAW'(1);
  assign w_tx_remain = r_orphan ? (r_tx_cnt != '0) : (r_tx_cnt > (TAW+1)'(1));
  assign w_tx_next   = r_orphan ? r_tx_mem[r_tx_rd] : r_tx_mem[w_tx_rd_nxt];
  assign w_status    = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 4'h0,
                        r_rx_ovf, w_tx_empty, w_tx_full, ~w_rx_empty};
  assign w_unused    = ^{addr[3], addr[1:0], wdata[31:8]};

  always_comb begin
    w_rdata_nxt = '0;
    if (w_wr)            w_rdata_nxt = '0;
    else if (w_stat)     w_rdata_nxt = w_status;
    else if (w_rx_empty) w_rdata_nxt = 32'hFFFF_FFFF;
    else                 w_rdata_nxt = {24'h0, r_rx_mem[r_rx_rd]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_acc & ~w_stall;
      r_rdata <= (w_acc & ~w_stall) ? w_rdata_nxt : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= uart_do;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_wr   <= '0;
      r_tx_rd   <= '0;
      r_tx_cnt  <= '0;
      r_uart_we <= 1'b0;
      r_uart_di <= '0;
      r_orphan  <= 1'b0;
    end else begin
      if (w_flush) begin
        r_tx_rd  <= r_tx_wr;
        r_tx_cnt <= '0;
      end else begin
        if (w_tx_push) r_tx_wr <= r_tx_wr + TAW'(1);
        if (w_tx_pop)  r_tx_rd <= w_tx_rd_nxt;
        r_tx_cnt <= r_tx_cnt + (TAW+1)'(w_tx_push) - (TAW+1)'(w_tx_pop);
      end
      // Head byte stays in the FIFO while presented; it retires on accept.
      if (w_accept) begin
        r_uart_we <= w_tx_remain & ~w_flush;
        if (w_tx_remain & ~w_flush) r_uart_di <= w_tx_next;
        r_orphan  <= 1'b0;
      end else if (!r_uart_we) begin
        if (!w_tx_empty && !w_flush) begin
          r_uart_we <= 1'b1;
          r_uart_di <= r_tx_mem[r_tx_rd];
        end
      end else if (w_flush) begin
        r_orphan <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_wr   <= '0;
      r_rx_rd   <= '0;
      r_rx_cnt  <= '0;
      r_rx_ovf  <= 1'b0;
      r_uart_re <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RAW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RAW'(1);
      r_rx_cnt  <= r_rx_cnt + (RAW+1)'(w_rx_push) - (RAW+1)'(w_rx_pop);
      if (uart_ready && w_rx_full) r_rx_ovf <= 1'b1;
      else if (w_ovf_clr)          r_rx_ovf <= 1'b0;
      r_uart_re <= (r_rx_cnt != RX_FULL);
    end
  end

  assign ready   = r_ready;
  assign rdata   = r_rdata;
  assign uart_we = r_uart_we;
  assign uart_di = r_uart_di;
  assign uart_re = r_uart_re;
endmodule

// File: tb/tb_usb_uart_fifo_bridge.sv
// Directed + randomized bench for usb_uart_fifo_bridge against a queue-based model.
module tb_usb_uart_fifo_bridge;
  logic        clk = 1'b0;
  logic        resetn, sel, ready, uart_we, uart_wait, uart_re, uart_ready;
  logic [3:0]  addr, wstrb;
  logic [31:0] wdata, rdata;
  logic [7:0]  uart_di, uart_do;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] recv[$];
  logic [7:0] rx_q[$];
  bit ovf = 1'b0;

  always #5 clk = ~clk;

  usb_uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .ready(ready), .rdata(rdata), .uart_we(uart_we), .uart_di(uart_di),
    .uart_wait(uart_wait), .uart_re(uart_re), .uart_do(uart_do), .uart_ready(uart_ready)
  );

  always @(negedge clk)
    if (resetn && uart_we && !uart_wait) recv.push_back(uart_di);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int txc);
    logic [31:0] s;
    s = 32'h0;
    s[0]     = (rx_q.size() != 0);
    s[1]     = (txc == 16);
    s[2]     = (txc == 0);
    s[3]     = ovf;
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(txc);
    return s;
  endfunction

  task automatic bus(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int lat);
    sel = 1'b1; addr = a; wdata = wd; wstrb = ws; lat = 0; rd = 'x;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (ready) begin lat = i; rd = rdata; break; end
    end
    sel = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic rd_status(input string tag, input int txc);
    logic [31:0] d; int lat;
    bus(4'h4, 32'h0, 4'h0, d, lat);
    check({tag, "_lat"}, lat, 1);
    check(tag, d, stat_exp(txc));
  endtask

  task automatic wr_data(input logic [7:0] b);
    logic [31:0] d; int lat;
    bus(4'h0, {24'h0, b}, 4'h1, d, lat);
    exp_tx.push_back(b);
    check("wr_lat", lat, 1);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] d, e; int lat;
    e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'hFFFF_FFFF;
    bus(4'h0, 32'h0, 4'h0, d, lat);
    check({tag, "_lat"}, lat, 1);
    check(tag, d, e);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    uart_do = b; uart_ready = 1'b1;
    @(posedge clk); #1;
    uart_ready = 1'b0;
    if (rx_q.size() < 16) rx_q.push_back(b); else ovf = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (recv.size() >= exp_tx.size() && !uart_we) break;
      @(posedge clk); #1;
    end
    check({tag, "_count"}, recv.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < recv.size(); i++)
      check({tag, "_byte"}, recv[i], exp_tx[i]);
    recv.delete(); exp_tx.delete();
  endtask

  initial begin
    logic [31:0] d; int lat; logic [7:0] b, first;
    resetn = 1'b0; sel = 1'b0; addr = 4'h0; wdata = 32'h0; wstrb = 4'h0;
    uart_wait = 1'b0; uart_do = 8'h0; uart_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_ready", ready, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_we", uart_we, 1'b0);
    check("rst_di", uart_di, 8'h0);
    check("rst_re", uart_re, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_status("status_reset", 0);
    check("idle_we", uart_we, 1'b0);
    check("idle_re", uart_re, 1'b1);

    wr_data(8'h41); wr_data(8'h42); wr_data(8'h43);
    drain("tx3");
    rd_status("status_txempty", 0);

    // Fill TX under back-pressure; the pointers wrap since three bytes already passed.
    uart_wait = 1'b1;
    for (int i = 0; i < 16; i++) wr_data(8'($urandom));
    rd_status("status_txfull", 16);
    check("full_we", uart_we, 1'b1);
    check("full_di", uart_di, exp_tx[0]);
    b = 8'($urandom);
    sel = 1'b1; addr = 4'h0; wdata = {24'h0, b}; wstrb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_ready", ready, 1'b0);
    end
    check("stall_di_hold", uart_di, exp_tx[0]);
    uart_wait = 1'b0;
    @(posedge clk); #1;
    check("stall_after_accept", ready, 1'b0);
    @(posedge clk); #1;
    check("stall_release", ready, 1'b1);
    sel = 1'b0; wstrb = 4'h0;
    exp_tx.push_back(b);
    @(posedge clk); #1;
    drain("tx17");

    pulse_rx(8'h55); pulse_rx(8'hAA);
    rd_status("status_rx2", 0);
    rd_data("rx_55"); rd_data("rx_aa"); rd_data("rx_empty");
    rd_status("status_rx0", 0);

    for (int i = 0; i < 16; i++) pulse_rx(8'($urandom));
    repeat (2) @(posedge clk); #1;
    check("rxfull_re", uart_re, 1'b0);
    pulse_rx(8'($urandom));
    rd_status("status_ovf", 0);
    bus(4'h4, 32'h8, 4'hF, d, lat);
    check("ovfclr_lat", lat, 1);
    ovf = 1'b0;
    rd_status("status_ovfclr", 0);
    for (int i = 0; i < 16; i++) rd_data("rx_fill");
    rd_data("rx_after_fill");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) rd_data("rx_rand");
      else pulse_rx(8'($urandom));
      if (i % 10 == 9) rd_status("status_rand", 0);
    end
    while (rx_q.size() != 0) rd_data("rx_flushout");
    bus(4'h4, 32'h8, 4'hF, d, lat);
    ovf = 1'b0;

    // Flush while a byte is presented: only that byte still goes out.
    uart_wait = 1'b1;
    for (int i = 0; i < 3; i++) wr_data(8'($urandom));
    bus(4'h4, 32'h2, 4'hF, d, lat);
    check("flush_lat", lat, 1);
    rd_status("status_flush", 0);
    check("flush_we", uart_we, 1'b1);
    check("flush_di", uart_di, exp_tx[0]);
    first = exp_tx[0];
    exp_tx.delete(); exp_tx.push_back(first);
    uart_wait = 1'b0;
    repeat (10) @(posedge clk); #1;
    drain("flush_tx");
    wr_data(8'($urandom));
    drain("post_flush");

    uart_wait = 1'b1;
    for (int i = 0; i < 16; i++) wr_data(8'($urandom));
    sel = 1'b1; addr = 4'h0; wdata = 32'h5A; wstrb = 4'h1;
    repeat (3) begin @(posedge clk); #1; check("pre_rst_stall", ready, 1'b0); end
    #3 resetn = 1'b0;
    #1;
    check("arst_ready", ready, 1'b0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_we", uart_we, 1'b0);
    check("arst_di", uart_di, 8'h0);
    check("arst_re", uart_re, 1'b0);
    repeat (3) begin @(posedge clk); #1; check("rst_hold_ready", ready, 1'b0); end
    sel = 1'b0; wstrb = 4'h0; uart_wait = 1'b0;
    exp_tx.delete(); rx_q.delete(); ovf = 1'b0;
    resetn = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("post_rst_we", uart_we, 1'b0);
    check("post_rst_recv", recv.size(), 0);
    rd_status("status_post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
